// File: rtl/mult_iter_pp_if.sv
`default_nettype none
// ============================================================================
// mult_iter_pp_if : operand-side and result-side valid/ready bundle for
//                   mult_iter_pp
// Rev 1.0
// ============================================================================
interface mult_iter_pp_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   o;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, o
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, o
  );
endinterface
`default_nettype wire

// File: rtl/mult_iter_pp.sv
`default_nettype none
// ============================================================================
// mult_iter_pp : iterative partial-product multiplier, BITS_PER_CYCLE y bits
//                retired per cycle through FA carry-save compression.
//                Define MULT_ITER_SIGNED_EN for two's complement operands.
// Rev 1.0
// ============================================================================
module mult_iter_pp #(
  parameter int WIDTH          = 4,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic          clk,
  input  logic          rst,
  mult_iter_pp_if.slave bus
);
  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
`ifdef MULT_ITER_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("mult_iter_pp: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     x_q, x_d, y_q, y_d;
  logic [W2-1:0]        acc_q, acc_d, o_q, o_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [W2-1:0]             x_ext;
  logic [BITS_PER_CYCLE-1:0] digit;
  logic [W2-1:0]             acc_next;

  always_comb begin
    if (SIGNED_MODE) x_ext = {{WIDTH{x_q[WIDTH-1]}}, x_q};
    else             x_ext = {{WIDTH{1'b0}}, x_q};
    digit = y_q[int'(cnt_q)*BITS_PER_CYCLE +: BITS_PER_CYCLE];
  end

  // Fold each AND-array row into a sum/carry pair, then resolve with a ripple
  // of FA cells. The negatively weighted top bit enters as ~row plus carry-in.
  always_comb begin
    logic [W2-1:0] sum_v;
    logic [W2-1:0] car_v;
    logic [W2-1:0] row;
    logic [W2-1:0] nsum;
    logic [W2-1:0] ncar;
    logic          cin;
    logic          c;
    sum_v = acc_q;
    car_v = '0;
    cin   = 1'b0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      row = digit[j] ? (x_ext << (int'(cnt_q)*BITS_PER_CYCLE + j)) : '0;
      if (SIGNED_MODE && cnt_q == LAST && j == BITS_PER_CYCLE-1 && digit[j]) begin
        row = ~row;
        cin = 1'b1;
      end
      nsum = '0;
      ncar = '0;
      for (int i = 0; i < W2; i++) begin
        nsum[i] = sum_v[i] ^ car_v[i] ^ row[i];
        if (i + 1 < W2) begin
          ncar[i+1] = (sum_v[i] & car_v[i]) | (sum_v[i] & row[i]) | (car_v[i] & row[i]);
        end
      end
      sum_v = nsum;
      car_v = ncar;
    end
    c        = cin;
    acc_next = '0;
    for (int i = 0; i < W2; i++) begin
      acc_next[i] = sum_v[i] ^ car_v[i] ^ c;
      c           = (sum_v[i] & car_v[i]) | (sum_v[i] & c) | (car_v[i] & c);
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.x;
          y_d     = bus.y;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          o_d     = acc_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.o         = o_q;
endmodule
`default_nettype wire

// File: tb/tb_mult_iter_pp.sv
`default_nettype none
// ============================================================================
// tb_mult_iter_pp : scoreboard bench for a 4x4/B=2 and an 8x8/B=1 instance
// Rev 1.0
// ============================================================================
module tb_mult_iter_pp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_iter_pp_if #(.WIDTH(4)) bus4 ();
  mult_iter_pp_if #(.WIDTH(8)) bus8 ();

  mult_iter_pp #(.WIDTH(4), .BITS_PER_CYCLE(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mult_iter_pp #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  q4 [$];
  logic [15:0] q8 [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product modulo 2^(2w), signed or unsigned to match the build.
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] mask;
    sa = longint'(a);
    sb = longint'(b);
`ifdef MULT_ITER_SIGNED_EN
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
`endif
    mask = (64'd1 << (2*w)) - 64'd1;
    return 64'(sa * sb) & mask;
  endfunction

  always @(negedge clk) begin
    #1;
    if (!rst && bus4.out_valid && bus4.out_ready) begin
      if (q4.size() == 0) check("dut4_spurious_out", 64'd1, 64'd0);
      else                check("dut4_product", 64'(bus4.o), 64'(q4.pop_front()));
    end
    if (!rst && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) check("dut8_spurious_out", 64'd1, 64'd0);
      else                check("dut8_product", 64'(bus8.o), 64'(q8.pop_front()));
    end
  end

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input int bp);
    logic [7:0] exp;
    int lat;
    exp = 8'(ref_prod(4, 32'(a), 32'(b)));
    @(negedge clk);
    check("dut4_in_ready_idle", 64'(bus4.in_ready), 64'd1);
    bus4.x = a; bus4.y = b; bus4.in_valid = 1'b1;
    bus4.out_ready = (bp == 0);
    q4.push_back(exp);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.x = 4'($urandom);
    bus4.y = 4'($urandom);
    check("dut4_in_ready_busy", 64'(bus4.in_ready), 64'd0);
    lat = 0;
    while (!bus4.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("dut4_latency", 64'(lat), 64'd2);
    check("dut4_in_ready_done", 64'(bus4.in_ready), 64'd0);
    for (int i = 0; i < bp; i++) begin
      check("dut4_hold_valid", 64'(bus4.out_valid), 64'd1);
      check("dut4_hold_o", 64'(bus4.o), 64'(exp));
      bus4.in_valid = (i == 1);
      @(negedge clk);
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    check("dut4_idle_after", {62'd0, bus4.in_ready, bus4.out_valid}, 64'd2);
    bus4.out_ready = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int lat;
    @(negedge clk);
    bus8.x = a; bus8.y = b; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    q8.push_back(16'(ref_prod(8, 32'(a), 32'(b))));
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.x = 8'($urandom);
    bus8.y = 8'($urandom);
    lat = 0;
    while (!bus8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("dut8_latency", 64'(lat), 64'd8);
    @(negedge clk);
    check("dut8_idle_after", {62'd0, bus8.in_ready, bus8.out_valid}, 64'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.x = '0; bus4.y = '0; bus4.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.x = '0; bus8.y = '0; bus8.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dut4_in_ready", 64'(bus4.in_ready), 64'd1);
    check("rst_dut4_out_valid", 64'(bus4.out_valid), 64'd0);
    check("rst_dut4_o", 64'(bus4.o), 64'd0);
    check("rst_dut8_state", {62'd0, bus8.in_ready, bus8.out_valid}, 64'd2);
    rst = 1'b0;

    op4(4'd15, 4'd15, 0);
    op4(4'd0,  4'd9,  0);
    op4(4'd1,  4'd13, 0);
    op4(4'd7,  4'd6,  5);
    op4(4'd8,  4'd8,  0);
    op4(4'd8,  4'd7,  0);
    op4(4'd15, 4'd1,  0);

    // abandon an operation on its first BUSY edge
    @(negedge clk);
    bus4.x = 4'd11; bus4.y = 4'd3; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 64'(bus4.in_ready), 64'd1);
    check("midrst_out_valid", 64'(bus4.out_valid), 64'd0);
    check("midrst_o", 64'(bus4.o), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_output", 64'(bus4.out_valid), 64'd0);
    end
    bus4.out_ready = 1'b0;

    for (int i = 0; i < 50; i++) op4(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));

    op8(8'd255, 8'd255);
    op8(8'd128, 8'd1);
    for (int i = 0; i < 1000; i++) op8(8'($urandom), 8'($urandom));

    repeat (3) @(negedge clk);
    check("q4_drained", 64'(q4.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
